radix4_modmul_seq: RTL and testbench

//   Sequential modular multiplier: r = (a*b) mod Q, one radix-4 digit of b per cycle.

---
 rtl/kyber_pkg.sv | 25 ++
 rtl/radix4_modmul_seq_if.sv | 35 +++
 rtl/radix4_pp_row.sv | 39 +++
 rtl/two_bit_multiplier.sv | 19 +
 rtl/radix4_modmul_seq.sv | 129 ++++++++++++
 tb/tb_radix4_modmul_seq.sv | 196 +++++++++++++++++++
 6 files changed

// File: rtl/kyber_pkg.sv
`default_nettype none
// ============================================================================
//  Package : kyber_pkg
//  Shared constants, FSM state type and modulus-multiple helper for the
//  butterfly datapath.
//  Rev 1.0 : initial release
// ============================================================================
package kyber_pkg;

    localparam int KYBER_Q = 3329;
    localparam int COEF_W  = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // k*q evaluated at elaboration time to build the reduction comparator table
    function automatic int kq_mult(input int k, input int q);
        return k * q;
    endfunction

endpackage
`default_nettype wire

// File: rtl/radix4_modmul_seq_if.sv
`default_nettype none
// ============================================================================
//  Interface : radix4_modmul_seq_if
//  Operand (valid/ready) and result (valid/ready) channels of the sequential
//  modular multiplier.
//  Rev 1.0 : initial release
// ============================================================================
interface radix4_modmul_seq_if
    import kyber_pkg::*;
#(
    parameter int W = COEF_W
) ();

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_r;

    // Upstream/downstream side: presents operands, accepts results
    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_r
    );

    // Multiplier side
    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_r
    );

endinterface
`default_nettype wire

// File: rtl/radix4_pp_row.sv
`default_nettype none
// ============================================================================
//  Module : radix4_pp_row
//  Combinational a x d for a W-bit multiplicand and one radix-4 digit d,
//  assembled from W/2 digit products with shifted adds.
//  Rev 1.0 : initial release
// ============================================================================
module radix4_pp_row #(
    parameter int W = 12
) (
    input  logic [W-1:0] a_i,
    input  logic [1:0]   d_i,
    output logic [W+1:0] p_o
);

    localparam int NDIG = W / 2;

    logic [3:0] pp_w [NDIG];

    generate
        for (genvar g = 0; g < NDIG; g++) begin : g_digit
            two_bit_multiplier u_mul (
                .a_i (a_i[2*g+1:2*g]),
                .b_i (d_i),
                .p_o (pp_w[g])
            );
        end
    endgenerate

    // Weight each digit product by 4**g and accumulate; max 3*(2**W-1) fits W+2 bits
    always_comb begin
        p_o = '0;
        for (int i = 0; i < NDIG; i++) begin
            p_o = p_o + ((W+2)'(pp_w[i]) << (2 * i));
        end
    end

endmodule
`default_nettype wire

// File: rtl/two_bit_multiplier.sv
`default_nettype none
// ============================================================================
//  Module : two_bit_multiplier
//  2-bit x 2-bit unsigned multiply producing a 4-bit digit product.
//  Rev 1.0 : initial release
// ============================================================================
module two_bit_multiplier (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic [3:0] p_o
);

    // Product of two radix-4 digits; fits in 4 bits (max 9)
    always_comb begin
        p_o = {2'b00, a_i} * {2'b00, b_i};
    end

endmodule
`default_nettype wire

// File: rtl/radix4_modmul_seq.sv
`default_nettype none
// ============================================================================
//  Module : radix4_modmul_seq
//  Sequential (a*b) mod Q, one radix-4 digit of b per cycle, MSB first
//  (Horner), with a full reduction into 0..Q-1 after every step.
//  Rev 1.0 : initial release
// ============================================================================
module radix4_modmul_seq
    import kyber_pkg::*;
#(
    parameter int W = COEF_W,
    parameter int Q = KYBER_Q
) (
    input  logic                clk,
    input  logic                rst_n,
    radix4_modmul_seq_if.slave  bus
);

    localparam int NDIG  = W / 2;
    localparam int CNT_W = $clog2(NDIG);

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, b_q, acc_q, out_r_q;
    logic [CNT_W-1:0] cnt_q;

    logic           accept_w, last_w;
    logic [1:0]     digit_w;
    logic [W+1:0]   pp_w;
    logic [W+2:0]   s_w;
    logic [W+2:0]   kq_w [8];
    logic [W-1:0]   sub_w, red_w;

    // Current digit of b, selected by the down-counting digit index
    assign digit_w = 2'(b_q >> {cnt_q, 1'b0});

    radix4_pp_row #(.W(W)) u_pp_row (
        .a_i (a_q),
        .d_i (digit_w),
        .p_o (pp_w)
    );

    // Horner step: 4*acc + a*d; acc < Q keeps this below 8*Q
    assign s_w = {1'b0, acc_q, 2'b00} + {1'b0, pp_w};

    // Multiples 0..7 of Q used as reduction thresholds
    generate
        for (genvar k = 0; k < 8; k++) begin : g_kq
            assign kq_w[k] = (W+3)'(kq_mult(k, Q));
        end
    endgenerate

    // Pick the largest k*Q not exceeding s; the thresholds ascend so the last hit wins.
    // Only the low W bits of the difference matter because the true result is < Q < 2**W.
    always_comb begin
        sub_w = '0;
        for (int k = 0; k < 8; k++) begin
            if (s_w >= kq_w[k]) begin
                sub_w = kq_w[k][W-1:0];
            end
        end
        red_w = s_w[W-1:0] - sub_w;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        state_d       = state_q;
        accept_w      = 1'b0;
        last_w        = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept_w = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    last_w  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture, accumulator/digit counter update and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_r_q <= '0;
        end else if (accept_w) begin
            a_q   <= bus.in_a;
            b_q   <= bus.in_b;
            acc_q <= '0;
            cnt_q <= CNT_W'(NDIG - 1);
        end else if (state_q == ST_RUN) begin
            acc_q <= red_w;
            cnt_q <= cnt_q - 1'b1;
            if (last_w) begin
                out_r_q <= red_w;
            end
        end
    end

    assign bus.out_r = out_r_q;

endmodule
`default_nettype wire

// File: tb/tb_radix4_modmul_seq.sv
`default_nettype none
// ============================================================================
//  Module : tb_radix4_modmul_seq
//  Directed and randomized self-checking bench for radix4_modmul_seq.
//  Rev 1.0 : initial release
// ============================================================================
module tb_radix4_modmul_seq;

    localparam int W      = 12;
    localparam int Q      = 3329;
    localparam int LAT    = 6;
    localparam int N_RAND = 3000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    radix4_modmul_seq_if #(.W(W)) bus ();

    radix4_modmul_seq #(.W(W), .Q(Q)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    function automatic int ref_mod(input int a, input int b);
        return (a * b) % Q;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full operation with out_ready held high; checks latency, result, return to idle
    task automatic op(input int a, input int b, input int exp, input string tag);
        int lat;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_a      = 12'(a);
        bus.in_b      = 12'(b);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(LAT));
        check({tag, "_r"}, 32'(bus.out_r), 32'(exp));
        @(negedge clk);
        check({tag, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int r0;
        int t;
        int ra, rb;
        int consumed;
        bit got;
        int exp_q[$];

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_r", 32'(bus.out_r), 32'd0);
        rst_n = 1'b1;

        // Directed arithmetic cases
        op(0, 1234, 0, "zero_a");
        op(3328, 3328, 1, "qm1_sq");
        op(17, 1729, 2761, "t17x1729");
        op(4095, 4095, 852, "max_unreduced");
        op(3329, 7, 0, "a_eq_q");
        op(4095, 0, 0, "b_zero");

        // Back-pressure: result held, new operands ignored
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_a      = 12'd100;
        bus.in_b      = 12'd200;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        t = 0;
        while (!bus.out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("bp_latency", 32'(t), 32'(LAT));
        r0 = ref_mod(100, 200);
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 12'd5;
            bus.in_b     = 12'd5;
            @(negedge clk);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_out_r", 32'(bus.out_r), 32'(r0));
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        op(11, 13, 143, "after_bp");

        // Asynchronous reset in the 3rd RUN cycle
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = 12'd1000;
        bus.in_b     = 12'd1000;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        check("arst_out_r", 32'(bus.out_r), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        op(5, 7, 35, "after_rst");

        // Randomized operands with random downstream readiness
        consumed = 0;
        for (int n = 0; n < N_RAND; n++) begin
            ra = int'($urandom_range(0, 4095));
            rb = int'($urandom_range(0, 4095));
            if (n % 97 == 0) ra = 4095;
            if (n % 89 == 0) rb = 3328;
            @(negedge clk);
            t = 0;
            while (!bus.in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) begin
                check("rand_in_timeout", 32'd1, 32'd0);
                break;
            end
            bus.in_valid  = 1'b1;
            bus.in_a      = 12'(ra);
            bus.in_b      = 12'(rb);
            bus.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            bus.in_valid = 1'b0;
            exp_q.push_back(ref_mod(ra, rb));
            got = 1'b0;
            t = 0;
            while (!got && t < 100) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                if (bus.out_valid && bus.out_ready) begin
                    check("rand_r", 32'(bus.out_r), 32'(exp_q.pop_front()));
                    consumed++;
                    got = 1'b1;
                end
                @(negedge clk);
                t++;
            end
            if (!got) begin
                check("rand_out_timeout", 32'd1, 32'd0);
                break;
            end
            check("rand_no_dup", 32'(bus.out_valid), 32'd0);
        end
        check("rand_consumed", 32'(consumed), 32'(N_RAND));
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
